// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer.
package piso_pkg;
    localparam int WORD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
endpackage

// File: rtl/piso_serializer_bit_cnt.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and terminal-count flag.
module bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/piso_serializer.sv
// Valid/ready parallel-in serial-out shifter with stall and done pulse.
// Optional even-parity trailer bit enabled by defining PIS_PARITY_EN.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             sen,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);
    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic             last_bit;
    logic             cnt_clr;
    logic             cnt_en;
`ifdef PIS_PARITY_EN
    logic             par_q;
`endif

    assign cnt_clr = (state == IDLE) && load_valid;
    assign cnt_en  = (state == SHIFT) && sen;

    bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (last_bit)
    );

    // sreg holds the bits not yet presented, aligned so the next one sits at the exit end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sreg         <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            load_ready   <= 1'b1;
            done         <= 1'b0;
`ifdef PIS_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        sreg         <= MSB_FIRST ? (parallel_in << 1) : (parallel_in >> 1);
                        serial_out   <= MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];
                        serial_valid <= 1'b1;
                        load_ready   <= 1'b0;
                        state        <= SHIFT;
`ifdef PIS_PARITY_EN
                        par_q        <= ^parallel_in;
`endif
                    end
                end
                SHIFT: begin
                    if (sen) begin
                        if (!last_bit) begin
                            serial_out <= MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
                            sreg       <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                        end else begin
`ifdef PIS_PARITY_EN
                            serial_out <= par_q;
                            state      <= PAR;
`else
                            serial_out   <= 1'b0;
                            serial_valid <= 1'b0;
                            done         <= 1'b1;
                            load_ready   <= 1'b1;
                            state        <= IDLE;
`endif
                        end
                    end
                end
`ifdef PIS_PARITY_EN
                PAR: begin
                    if (sen) begin
                        serial_out   <= 1'b0;
                        serial_valid <= 1'b0;
                        done         <= 1'b1;
                        load_ready   <= 1'b1;
                        state        <= IDLE;
                    end
                end
`endif
                default: begin
                    serial_out   <= 1'b0;
                    serial_valid <= 1'b0;
                    load_ready   <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a queue-based word model.
module tb_piso_serializer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] parallel_in = '0;
    logic         load_valid = 1'b0;
    logic         sen = 1'b0;
    logic         ready_m, out_m, valid_m, done_m;
    logic         ready_l, out_l, valid_l, done_l;

    int checks = 0;
    int errors = 0;

    // model: words are expanded into expected bit queues at acceptance time
    bit q_m[$];
    bit q_l[$];
    bit busy = 1'b0;
    bit e_out_m = 1'b0, e_out_l = 1'b0, e_valid = 1'b0, e_ready = 1'b1, e_done = 1'b0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .parallel_in(parallel_in), .load_valid(load_valid),
        .load_ready(ready_m), .sen(sen), .serial_out(out_m), .serial_valid(valid_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .parallel_in(parallel_in), .load_valid(load_valid),
        .load_ready(ready_l), .sen(sen), .serial_out(out_l), .serial_valid(valid_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            busy = 0; q_m.delete(); q_l.delete();
            e_out_m = 0; e_out_l = 0; e_valid = 0; e_ready = 1; e_done = 0;
        end else begin
            e_done = 0;
            if (!busy) begin
                if (load_valid) begin
                    q_m.delete(); q_l.delete();
                    for (int i = 0; i < W; i++) begin
                        q_m.push_back(parallel_in[W-1-i]);
                        q_l.push_back(parallel_in[i]);
                    end
`ifdef PIS_PARITY_EN
                    q_m.push_back(^parallel_in);
                    q_l.push_back(^parallel_in);
`endif
                    e_out_m = q_m.pop_front();
                    e_out_l = q_l.pop_front();
                    e_valid = 1; e_ready = 0; busy = 1;
                end
            end else if (sen) begin
                if (q_m.size() > 0) begin
                    e_out_m = q_m.pop_front();
                    e_out_l = q_l.pop_front();
                end else begin
                    e_out_m = 0; e_out_l = 0; e_valid = 0; e_ready = 1; e_done = 1; busy = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit lv, input logic [W-1:0] pi, input bit s);
        rst = r; load_valid = lv; parallel_in = pi; sen = s;
        @(posedge clk);
        model_edge();
        #1;
        chk("msb.serial_out",   out_m,   e_out_m);
        chk("msb.serial_valid", valid_m, e_valid);
        chk("msb.load_ready",   ready_m, e_ready);
        chk("msb.done",         done_m,  e_done);
        chk("lsb.serial_out",   out_l,   e_out_l);
        chk("lsb.serial_valid", valid_l, e_valid);
        chk("lsb.load_ready",   ready_l, e_ready);
        chk("lsb.done",         done_l,  e_done);
    endtask

    initial begin
        // reset held with a pending load: nothing may be captured
        step(1, 1, 4'b1111, 1);
        step(1, 1, 4'b1111, 1);
        chk("reset.ready_const", ready_m, 1'b1);
        chk("reset.valid_const", valid_m, 1'b0);

        // plain word, continuous enable, then idle cycles
        step(0, 1, 4'b1010, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 4'b0000, 1);

        // stall after the second bit
        step(0, 1, 4'b0101, 1);
        step(0, 0, 4'b0000, 1);
        step(0, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 4'b0000, 1);

        // load attempts while busy must be ignored
        step(0, 1, 4'b1010, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 4'b1111, 1);
        step(0, 0, 4'b0000, 1);

        // reset mid-shift aborts without done, then a fresh word
        step(0, 1, 4'b0111, 1);
        step(0, 0, 4'b0000, 1);
        step(1, 0, 4'b0000, 1);
        step(0, 1, 4'b1011, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 4'b0000, 1);

        // back-to-back: load held high so each done cycle accepts the next word
        for (int i = 0; i < 14; i++) step(0, 1, 4'(i * 3 + 5), 1);
        step(0, 0, 4'b0000, 1);
        step(0, 0, 4'b0000, 1);

        // randomized traffic with stalls, busy loads and occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 1) == 1),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly downstream of the 4-bit enabled parallel register.
- Accepts a WIDTH-bit word from the register's parallel output through a valid/ready handshake.
- Shifts the word out one bit per enabled clock, with a stall input, and pulses done when the word is finished.
- Feeds the serial link and bit-level consumers in later labs.

Parameters:
- WIDTH, 4, word width in bits; must be at least 2.
- MSB_FIRST, 1, 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- parallel_in  input  WIDTH  word to serialise, normally driven by the register's parallel_out
- load_valid  input  1  parallel_in holds a word to accept
- load_ready  output  1  block is idle and can accept a word
- sen  input  1  shift enable; 0 stalls the shift
- serial_out  output  1  current serial bit
- serial_valid  output  1  serial_out carries a data bit (or the parity bit)
- done  output  1  one-cycle pulse after the final bit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled only at the posedge of clk.
- Reset values, all registered: serial_out=0, serial_valid=0, load_ready=1, done=0, shift register=0, bit counter=0, state=IDLE.
- State machine: IDLE, SHIFT, plus PAR when PARITY_EN is defined.
- IDLE:
  - load_ready=1.
  - At a posedge with load_valid=1, capture parallel_in and set cnt=0.
  - On that same edge, drive serial_out with the first bit and set serial_valid=1, load_ready=0, state=SHIFT.
  - Latency: the first bit is visible one edge after acceptance. sen is ignored in IDLE.
- SHIFT:
  - Posedge with sen=1 and cnt<WIDTH-1: present the next bit and increment cnt.
  - Posedge with sen=0: hold serial_out, cnt and state unchanged.
  - Posedge with sen=1 and cnt==WIDTH-1, PARITY_EN undefined: serial_valid=0, serial_out=0, done=1, load_ready=1, state=IDLE.
  - Posedge with sen=1 and cnt==WIDTH-1, PARITY_EN defined: state=PAR, serial_out=parity bit, serial_valid stays 1.
- PAR:
  - Posedge with sen=1: same exit as the last-bit exit of SHIFT (done=1, load_ready=1, return to IDLE).
  - Posedge with sen=0: hold.
- done is high for exactly one cycle, the first cycle back in IDLE. It is cleared on the next edge regardless of inputs.
- With continuous sen=1, each bit is held exactly one cycle. A word therefore takes WIDTH cycles (WIDTH+1 with parity) of serial_valid, followed by one done cycle.
- load_valid while busy (load_ready=0): ignored. The word is not captured and the current word is unaffected.
- Back-to-back words: a load accepted in the done cycle starts the next word immediately, giving one idle bubble between words.
- Reset mid-operation: rst dominates every other input. The word is aborted, no done pulse is produced, and all outputs take reset values at that edge.
- The bit counter is sized $clog2(WIDTH) bits and wraps to 0 on each new load.

Optional Feature:
- Macro: PIS_PARITY_EN.
- Defined: after the last data bit the PAR state emits one even-parity bit, equal to the XOR of the captured word, with serial_valid=1. The parity bit obeys sen stalls, and done follows it.
- Undefined: the PAR state and parity logic are absent, and done follows the last data bit directly.

Decomposition:
- Package piso_pkg: the state enum typedef (IDLE, SHIFT, PAR) and the default width constant WORD_W=4.
- Sub-module bit_cnt: a modulo-WIDTH counter with synchronous clear, an enable input and a terminal-count output (cnt==WIDTH-1).
- The top level holds the FSM, the shift register and the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with load_valid=1 -> serial_valid=0, serial_out=0, load_ready=1, done=0; no word captured.
- MSB_FIRST=1, load 4'b1010, sen=1 throughout -> serial_out 1,0,1,0 on 4 consecutive cycles with serial_valid=1, then done=1 for 1 cycle with load_ready=1.
- Stall: load 4'b0101, sen=0 for 2 cycles after the second bit -> the second bit (1) is held for 3 cycles; sequence 0,1,1,1,0,1; done after 6 valid cycles.
- Busy load: while 4'b1010 is shifting, present load_valid=1 with 4'b1111 -> ignored; output stays 1,0,1,0 and load_ready=0 until done.
- Reset mid-shift: assert rst after 2 bits of 4'b0111 -> all outputs at reset values next edge, no done pulse; a following load of 4'b1011 serialises 1,0,1,1.
- PIS_PARITY_EN defined: load 4'b1011 -> 1,0,1,1, then parity 1, then done; with MSB_FIRST=0, the same word gives 1,1,0,1, then 1.
